// File: rtl/data_sram_like_bridge.sv
// Bridges single-cycle MEM-stage data requests onto the SRAM-like split
// handshake bus (req/addr_ok, then data_ok), stalling the pipeline until data returns.
module data_sram_like_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  sel,
  input  logic [1:0]  mem_size,
  input  logic        cpu_stall,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_strb_q;
  logic [31:0] rdata_q;
  logic [31:0] paddr;
  logic        issue;

  // kseg0/kseg1 alias onto low physical memory by dropping the segment bits
  always_comb begin
    paddr = mem_addr;
    if (KSEG_MAP && (mem_addr[31:30] == 2'b10)) begin
      paddr = {3'b000, mem_addr[28:0]};
    end
  end

  // Gating with rst keeps every output at zero while reset is held
  assign issue = (state_q == IDLE) && mem_en && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_strb_q  <= 4'd0;
      rdata_q     <= 32'd0;
    end else begin
      if ((state_q == IDLE) && mem_en) begin
        req_wr_q    <= mem_we;
        req_size_q  <= mem_size;
        req_addr_q  <= paddr;
        req_wdata_q <= mem_wdata;
        req_strb_q  <= mem_we ? sel : 4'b0000;
      end
      if ((state_q == DATA) && data_data_ok) begin
        rdata_q <= data_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_en) state_d = data_addr_ok ? DATA : ADDR;
      ADDR: if (data_addr_ok) state_d = DATA;
      DATA: if (data_data_ok) state_d = cpu_stall ? DONE : IDLE;
      DONE: if (!cpu_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE parks the result so a still-stalled instruction is not re-issued
  always_comb begin
    data_req          = 1'b0;
    stallreq_from_mem = 1'b0;
    mem_rdata         = rdata_q;
    data_wr           = req_wr_q;
    data_size         = req_size_q;
    data_addr         = req_addr_q;
    data_wdata        = req_wdata_q;
    data_wstrb        = req_strb_q;
    case (state_q)
      IDLE: begin
        if (rst) begin
          data_wr    = 1'b0;
          data_size  = 2'd0;
          data_addr  = 32'd0;
          data_wdata = 32'd0;
          data_wstrb = 4'd0;
        end else begin
          data_wr    = mem_we;
          data_size  = mem_size;
          data_addr  = paddr;
          data_wdata = mem_wdata;
          data_wstrb = mem_we ? sel : 4'b0000;
        end
        data_req          = issue;
        stallreq_from_mem = issue;
      end
      ADDR: begin
        data_req          = 1'b1;
        stallreq_from_mem = 1'b1;
      end
      DATA: begin
        stallreq_from_mem = !data_data_ok;
        if (data_data_ok) mem_rdata = data_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: a linear sequence of bus scenarios
// with a queue of expected load data popped when each transaction completes.
module tb_data_sram_like_bridge;

  logic        clk, rst;
  logic        mem_en, mem_we, cpu_stall;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  sel;
  logic [1:0]  mem_size;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] mem_rdata, data_addr, data_wdata;
  logic        stallreq_from_mem, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  logic [31:0] m0_mem_rdata, m0_data_addr, m0_data_wdata;
  logic        m0_stallreq, m0_data_req, m0_data_wr;
  logic [1:0]  m0_data_size;
  logic [3:0]  m0_data_wstrb;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          accept_count = 0;
  int          base_count;
  int          req_cycles, stall_cycles;
  logic [31:0] exp_q[$];

  data_sram_like_bridge #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sel(sel), .mem_size(mem_size), .cpu_stall(cpu_stall),
    .mem_rdata(mem_rdata), .stallreq_from_mem(stallreq_from_mem), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  data_sram_like_bridge #(.KSEG_MAP(1'b0)) dut_nomap (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sel(sel), .mem_size(mem_size), .cpu_stall(cpu_stall),
    .mem_rdata(m0_mem_rdata), .stallreq_from_mem(m0_stallreq), .data_req(m0_data_req),
    .data_wr(m0_data_wr), .data_size(m0_data_size), .data_addr(m0_data_addr),
    .data_wdata(m0_data_wdata), .data_wstrb(m0_data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted address handshakes on the mapped instance
  always @(posedge clk) begin
    if (data_req && data_addr_ok) accept_count <= accept_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkPop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
    end else begin
      checkOutput(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [1:0] size);
    mem_en    = en;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    sel       = be;
    mem_size  = size;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic busIdle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    busIdle();
    #1;
    checkOutput("reset_stall", {31'd0, stallreq_from_mem}, 32'd0);
    checkOutput("reset_req", {31'd0, data_req}, 32'd0);
    checkOutput("reset_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait load through kseg1
    applyStimulus(1'b1, 1'b0, 32'h9FC0_0010, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    checkOutput("zw_req", {31'd0, data_req}, 32'd1);
    checkOutput("zw_addr", data_addr, 32'h1FC0_0010);
    checkOutput("zw_wstrb", {28'd0, data_wstrb}, 32'd0);
    checkOutput("zw_wr", {31'd0, data_wr}, 32'd0);
    checkOutput("zw_stall_issue", {31'd0, stallreq_from_mem}, 32'd1);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    #1;
    checkOutput("zw_stall_done", {31'd0, stallreq_from_mem}, 32'd0);
    checkOutput("zw_req_done", {31'd0, data_req}, 32'd0);
    checkPop("zw_rdata", mem_rdata);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    busIdle();
    #1;
    checkOutput("zw_rdata_hold", mem_rdata, 32'hDEAD_BEEF);

    // Waited byte store: addr_ok on the 4th request cycle, data_ok 3 cycles later
    applyStimulus(1'b1, 1'b1, 32'hBFC0_0002, 32'h00AB_0000, 4'b0100, 2'd0);
    exp_q.push_back(32'h1122_3344);
    req_cycles = 0;
    stall_cycles = 0;
    for (int c = 0; c < 7; c++) begin
      data_addr_ok = (c == 3);
      data_data_ok = (c == 6);
      data_rdata   = (c == 6) ? 32'h1122_3344 : 32'h9999_9999;
      #1;
      if (data_req) begin
        req_cycles++;
        checkOutput("st_addr", data_addr, 32'h1FC0_0002);
        checkOutput("st_wdata", data_wdata, 32'h00AB_0000);
        checkOutput("st_wstrb", {28'd0, data_wstrb}, 32'h4);
        checkOutput("st_size", {30'd0, data_size}, 32'd0);
        checkOutput("st_wr", {31'd0, data_wr}, 32'd1);
      end
      if (stallreq_from_mem) stall_cycles++;
      if (c == 6) checkPop("st_rdata", mem_rdata);
      cycle();
    end
    checkOutput("st_req_cycles", req_cycles, 32'd4);
    checkOutput("st_stall_cycles", stall_cycles, 32'd6);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    busIdle();

    // Completion while another unit holds the pipeline
    base_count = accept_count;
    applyStimulus(1'b1, 1'b0, 32'h0040_0000, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    checkOutput("hold_addr_unmapped", data_addr, 32'h0040_0000);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    cpu_stall    = 1'b1;
    #1;
    checkPop("hold_rdata", mem_rdata);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cpu_stall    = (i < 4);
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h0BAD_BAD0;
      #1;
      checkOutput("hold_done_req", {31'd0, data_req}, 32'd0);
      checkOutput("hold_done_stall", {31'd0, stallreq_from_mem}, 32'd0);
      checkOutput("hold_done_rdata", mem_rdata, 32'hCAFE_F00D);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    busIdle();
    cpu_stall = 1'b0;
    #1;
    checkOutput("hold_idle_rdata", mem_rdata, 32'hCAFE_F00D);
    checkOutput("hold_one_request", accept_count - base_count, 32'd1);

    // Address mapping on and off for a kseg1 address
    applyStimulus(1'b1, 1'b0, 32'hA000_0004, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    exp_q.push_back(32'h4444_4444);
    #1;
    checkOutput("nomap_addr", m0_data_addr, 32'hA000_0004);
    checkOutput("map_addr", data_addr, 32'h0000_0004);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h4444_4444;
    #1;
    checkPop("map_rdata", mem_rdata);
    cycle();

    // Back-to-back zero-wait loads; stale data_ok in the second issue cycle
    base_count = accept_count;
    applyStimulus(1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b0;
    exp_q.push_back(32'h0101_0101);
    exp_q.push_back(32'h0202_0202);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0101_0101;
    #1;
    checkPop("b2b_first", mem_rdata);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h7777_7777;
    #1;
    checkOutput("b2b_second_stall", {31'd0, stallreq_from_mem}, 32'd1);
    checkOutput("b2b_second_addr", data_addr, 32'h0000_0200);
    checkOutput("b2b_ignore_stale", mem_rdata, 32'h0101_0101);
    cycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0202_0202;
    #1;
    checkPop("b2b_second", mem_rdata);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    busIdle();
    #1;
    checkOutput("b2b_two_requests", accept_count - base_count, 32'd2);

    // Reset while waiting for data_ok
    applyStimulus(1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'hF, 2'd2);
    data_addr_ok = 1'b1;
    #1;
    checkOutput("rst_issue_addr", data_addr, 32'h0000_1000);
    cycle();
    data_addr_ok = 1'b0;
    #1;
    checkOutput("rst_data_wait", {31'd0, stallreq_from_mem}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_stall", {31'd0, stallreq_from_mem}, 32'd0);
    checkOutput("rst_mid_req", {31'd0, data_req}, 32'd0);
    checkOutput("rst_mid_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_5555;
    #1;
    checkOutput("rst_after_stall", {31'd0, stallreq_from_mem}, 32'd0);
    checkOutput("rst_after_rdata", mem_rdata, 32'd0);
    cycle();
    busIdle();
    #1;
    checkOutput("rst_stale_ignored", mem_rdata, 32'd0);
    mem_en = 1'b1;
    #1;
    checkOutput("rst_back_in_idle", {31'd0, stallreq_from_mem}, 32'd1);
    mem_en = 1'b0;

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
- Responder for the datapath's data-memory port. Accepts single-cycle SRAM-style data requests (mem_en, mem_we, sel, mem_size, address, write data) from the MEM stage.
- Converts each request into one transaction on the SRAM-like split handshake bus: req/addr_ok, then data_ok.
- Returns read data on mem_rdata and holds the pipeline via stallreq_from_mem until the transaction completes.
- Sits between the CPU kernel and the AXI/cache wrapper.

Parameters:
- KSEG_MAP, 1: when 1, addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared before reaching the bus; other addresses pass unchanged. When 0, all addresses pass unchanged.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- mem_en  in  1  data access request from the MEM stage; held stable while the pipeline is stalled.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  virtual byte address (the MEM-stage ALU result).
- mem_wdata  in  32  store data, already lane-aligned.
- sel  in  4  byte enables.
- mem_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_stall  in  1  pipeline hold from any source other than this block; MEM does not advance while high.
- mem_rdata  out  32  load data returned to the MEM stage.
- stallreq_from_mem  out  1  holds the pipeline while a transaction is pending.
- data_req  out  1  bus request.
- data_wr  out  1  bus write flag.
- data_size  out  2  bus transfer size.
- data_addr  out  32  bus physical address.
- data_wdata  out  32  bus write data.
- data_wstrb  out  4  bus write strobes.
- data_addr_ok  in  1  bus address handshake accept.
- data_data_ok  in  1  bus data phase complete.
- data_rdata  in  32  bus read data.

Behaviour:
- States: IDLE, ADDR, DATA, DONE. Reset → IDLE.
- Reset (asynchronous, any time, including mid-transaction): all registers clear, every output reads 0, any outstanding bus transaction is abandoned.
- Request capture: registers req_q = {wr, size, paddr, wdata, strb}.
  - In IDLE the bus fields are driven combinationally from the CPU inputs.
  - In ADDR the bus fields are driven from req_q.
  - req_q is loaded on every clock edge in IDLE where mem_en=1.
- data_wstrb = sel when the access is a write, 4'b0000 when it is a read.
- data_req = (IDLE & mem_en) | ADDR.
- IDLE:
  - mem_en=0: remain in IDLE.
  - mem_en=1 and data_addr_ok=1: go to DATA.
  - mem_en=1 and data_addr_ok=0: go to ADDR.
- ADDR:
  - data_addr_ok=1: go to DATA.
  - Otherwise remain in ADDR with data_req held at 1 and the bus fields unchanged.
- DATA (no new requests are issued):
  - data_data_ok=1: rdata_q ← data_rdata. If cpu_stall=1 go to DONE, else go to IDLE.
  - data_data_ok=0: remain in DATA.
- DONE:
  - data_req=0 and stallreq_from_mem=0; mem_rdata = rdata_q.
  - cpu_stall=0: go to IDLE.
  - This prevents re-issuing the same instruction's access while another unit holds the pipeline.
- stallreq_from_mem = (IDLE & mem_en) | ADDR | (DATA & ~data_data_ok). Combinational, with no registered delay.
- mem_rdata = (DATA & data_data_ok) ? data_rdata : rdata_q. The bypass gives zero added latency on the completion cycle.
- Minimum load latency: issue cycle + 1 → data returns in the second cycle. stallreq_from_mem is high for exactly 1 cycle when addr_ok arrives in the issue cycle and data_ok arrives in the next.
- Stores follow the same handshake; rdata_q is still loaded from data_rdata, and the CPU ignores it for stores.
- Protocol limits:
  - data_data_ok is ignored outside DATA.
  - data_addr_ok is ignored outside IDLE (with mem_en=1) and ADDR.
  - At most one outstanding transaction.
- Once a request has been issued, a change or drop of mem_en does not abort it; the transaction completes. Only reset aborts.
- Back-to-back accesses: the edge leaving DATA or DONE for IDLE coincides with the pipeline advancing, so the next cycle's mem_en belongs to the next instruction.

Test Plan:
- Reset mid-DATA: load to 0x8000_1000, assert rst while the FSM is in DATA → stallreq_from_mem=0, data_req=0, mem_rdata=0 immediately. After release, FSM is IDLE and the stale data_ok is ignored.
- Zero-wait load: mem_en=1, mem_we=0, mem_addr=0x9FC0_0010, addr_ok in the same cycle, data_ok next cycle with data_rdata=0xDEADBEEF → data_addr=0x1FC0_0010, data_wstrb=0, stallreq_from_mem high for 1 cycle, mem_rdata=0xDEADBEEF in the completion cycle.
- Waited store: sb, sel=4'b0100, mem_wdata=0x00AB0000, mem_size=0, addr_ok after 3 cycles, data_ok after 2 more → data_req high for 4 cycles with fields constant, data_wr=1, data_wstrb=4'b0100, data_size=0, stallreq_from_mem high for 6 cycles total.
- Held pipeline: data_ok arrives while cpu_stall=1 for 4 more cycles → FSM in DONE, data_req stays 0, mem_rdata holds the value. After cpu_stall drops, FSM returns to IDLE and exactly one bus request is counted.
- KSEG_MAP=0 with address 0xA000_0004 → data_addr=0xA000_0004. KSEG_MAP=1 with address 0x0040_0000 → data_addr=0x0040_0000 unchanged.
- Back-to-back loads in consecutive instructions with zero-wait responses → two distinct requests, no duplicate issue, each mem_rdata matching its own data_rdata.
